// File: rtl/zynq_axil_fifo_bridge_if.sv
// AXI4-Lite bus between the PS-side master and the FIFO bridge slave.
interface zynq_axil_fifo_bridge_if #(
  parameter int addr_width_p = 10
) ();
  logic [addr_width_p-1:0] awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [addr_width_p-1:0] araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/zynq_axil_fifo_bridge.sv
// AXI4-Lite slave that turns register accesses into PS->PL / PL->PS word streams,
// with a scratch register, occupancy CSRs and a sticky RW1C error register.

module zynq_axil_fifo_bridge_fifo #(
  parameter int width_p = 32,
  parameter int els_p   = 16,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = ptr_w_lp + 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                push_i,
  input  logic [width_p-1:0]  data_i,
  input  logic                pop_i,
  output logic [width_p-1:0]  data_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [cnt_w_lp-1:0] count_o
);
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;

  // Pointer/count update; the caller never pops when empty nor pushes when full without a pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge aclk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == els_lp);
  assign count_o = count_q;
endmodule

module zynq_axil_fifo_bridge #(
  parameter int addr_width_p = 10,
  parameter int data_width_p = 32,
  parameter int fifo_els_p   = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  zynq_axil_fifo_bridge_if.slave  s00,
  output logic [data_width_p-1:0] ps2pl_data_o,
  output logic                    ps2pl_v_o,
  input  logic                    ps2pl_ready_i,
  input  logic [data_width_p-1:0] pl2ps_data_i,
  input  logic                    pl2ps_v_i,
  output logic                    pl2ps_ready_o
);
  localparam int cnt_w_lp = $clog2(fifo_els_p) + 1;
  localparam int idx_w_lp = addr_width_p - 2;
  localparam logic [idx_w_lp-1:0] map_end_lp  = idx_w_lp'(6);
  localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(fifo_els_p);
  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;
  localparam logic [3:0] reg_scratch_lp = 4'd0;
  localparam logic [3:0] reg_free_lp    = 4'd1;
  localparam logic [3:0] reg_occ_lp     = 4'd2;
  localparam logic [3:0] reg_pop_lp     = 4'd4;
  localparam logic [3:0] reg_push_lp    = 4'd3;
  localparam logic [3:0] reg_err_lp     = 4'd5;

  logic                    out_en_q, out_en_d;
  logic                    aw_held_q, aw_held_d;
  logic [addr_width_p-1:0] aw_addr_q, aw_addr_d;
  logic                    w_held_q, w_held_d;
  logic [31:0]             w_data_q, w_data_d;
  logic [3:0]              w_strb_q, w_strb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [31:0]             scratch_q, scratch_d;
  logic [3:0]              err_q, err_d;

  logic                    aw_hs_s, w_hs_s, ar_hs_s, wr_exec_s;
  logic                    wr_mapped_s, rd_mapped_s;
  logic [3:0]              wr_idx_s, rd_idx_s;
  logic [3:0]              err_set_wr_s, err_set_rd_s, err_clr_s;
  logic                    ps2pl_push_s, ps2pl_pop_s, ps2pl_empty_s, ps2pl_full_s;
  logic                    pl2ps_push_s, pl2ps_pop_s, pl2ps_empty_s, pl2ps_full_s;
  logic [cnt_w_lp-1:0]     ps2pl_count_s, pl2ps_count_s, ps2pl_free_s;
  logic [31:0]             pl2ps_head_s;
  logic                    unused_s;

  assign s00.awready = out_en_q & ~aw_held_q & ~bvalid_q;
  assign s00.wready  = out_en_q & ~w_held_q & ~bvalid_q;
  assign s00.arready = out_en_q & ~rvalid_q;
  assign s00.bvalid  = bvalid_q;
  assign s00.bresp   = bresp_q;
  assign s00.rvalid  = rvalid_q;
  assign s00.rdata   = rdata_q;
  assign s00.rresp   = rresp_q;

  assign aw_hs_s     = s00.awvalid & s00.awready;
  assign w_hs_s      = s00.wvalid & s00.wready;
  assign ar_hs_s     = s00.arvalid & s00.arready;
  assign wr_exec_s   = aw_held_q & w_held_q & ~bvalid_q;
  // Full-address range check so aliases above 0x17 decode as unmapped.
  assign wr_mapped_s = (aw_addr_q[addr_width_p-1:2] < map_end_lp);
  assign rd_mapped_s = (s00.araddr[addr_width_p-1:2] < map_end_lp);
  assign wr_idx_s    = aw_addr_q[5:2];
  assign rd_idx_s    = s00.araddr[5:2];

  assign ps2pl_v_o     = ~ps2pl_empty_s;
  assign ps2pl_pop_s   = ps2pl_v_o & ps2pl_ready_i;
  assign pl2ps_ready_o = out_en_q & ~pl2ps_full_s;
  assign pl2ps_push_s  = pl2ps_v_i & pl2ps_ready_o;
  assign ps2pl_free_s  = els_lp - ps2pl_count_s;
  assign unused_s      = ^{s00.awprot, s00.arprot, aw_addr_q[1:0], s00.araddr[1:0]};

  // Write path: independent AW/W capture, execution once both are held, B handshake.
  always_comb begin
    out_en_d     = 1'b1;
    aw_held_d    = aw_held_q;
    aw_addr_d    = aw_addr_q;
    w_held_d     = w_held_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    scratch_d    = scratch_q;
    err_set_wr_s = 4'b0000;
    err_clr_s    = 4'b0000;
    ps2pl_push_s = 1'b0;

    if (aw_hs_s) begin
      aw_held_d = 1'b1;
      aw_addr_d = s00.awaddr;
    end else if (wr_exec_s) begin
      aw_held_d = 1'b0;
    end else begin
      aw_held_d = aw_held_q;
    end

    if (w_hs_s) begin
      w_held_d = 1'b1;
      w_data_d = s00.wdata;
      w_strb_d = s00.wstrb;
    end else if (wr_exec_s) begin
      w_held_d = 1'b0;
    end else begin
      w_held_d = w_held_q;
    end

    if (wr_exec_s) begin
      bvalid_d = 1'b1;
      bresp_d  = resp_okay_lp;
      if (!wr_mapped_s) begin
        bresp_d         = resp_slverr_lp;
        err_set_wr_s[3] = 1'b1;
      end else begin
        case (wr_idx_s)
          reg_scratch_lp: begin
            for (int i = 0; i < 4; i++) begin
              if (w_strb_q[i]) begin
                scratch_d[8*i +: 8] = w_data_q[8*i +: 8];
              end else begin
                scratch_d[8*i +: 8] = scratch_q[8*i +: 8];
              end
            end
          end
          reg_push_lp: begin
            // Fullness is judged on the registered count, before any same-cycle pop.
            if (w_strb_q != 4'hF) begin
              bresp_d         = resp_slverr_lp;
              err_set_wr_s[2] = 1'b1;
            end else if (ps2pl_full_s) begin
              bresp_d         = resp_slverr_lp;
              err_set_wr_s[0] = 1'b1;
            end else begin
              ps2pl_push_s = 1'b1;
            end
          end
          reg_err_lp: err_clr_s = w_data_q[3:0];
          default: begin
            bresp_d         = resp_slverr_lp;
            err_set_wr_s[3] = 1'b1;
          end
        endcase
      end
    end else if (bvalid_q && s00.bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // Read path: decode and capture at AR acceptance, hold until R handshake.
  always_comb begin
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    err_set_rd_s = 4'b0000;
    pl2ps_pop_s  = 1'b0;

    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = 32'h0000_0000;
      rresp_d  = resp_okay_lp;
      if (!rd_mapped_s) begin
        rresp_d         = resp_slverr_lp;
        err_set_rd_s[3] = 1'b1;
      end else begin
        case (rd_idx_s)
          reg_scratch_lp: rdata_d = scratch_q;
          reg_free_lp:    rdata_d = {{(32-cnt_w_lp){1'b0}}, ps2pl_free_s};
          reg_occ_lp:     rdata_d = {{(32-cnt_w_lp){1'b0}}, pl2ps_count_s};
          reg_pop_lp: begin
            if (pl2ps_empty_s) begin
              rresp_d         = resp_slverr_lp;
              err_set_rd_s[1] = 1'b1;
            end else begin
              rdata_d     = pl2ps_head_s;
              pl2ps_pop_s = 1'b1;
            end
          end
          reg_err_lp: rdata_d = {28'h000_0000, err_q};
          default: begin
            rresp_d         = resp_slverr_lp;
            err_set_rd_s[3] = 1'b1;
          end
        endcase
      end
    end else if (rvalid_q && s00.rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Sticky error bits: a same-cycle set overrides the RW1C clear.
  always_comb begin
    err_d = (err_q & ~err_clr_s) | err_set_wr_s | err_set_rd_s;
  end

  // Bridge state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= 32'h0000_0000;
      w_strb_q  <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      rresp_q   <= 2'b00;
      scratch_q <= 32'h0000_0000;
      err_q     <= 4'h0;
    end else begin
      out_en_q  <= out_en_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      scratch_q <= scratch_d;
      err_q     <= err_d;
    end
  end

  zynq_axil_fifo_bridge_fifo #(.width_p(32), .els_p(fifo_els_p)) ps2pl_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (ps2pl_push_s),
    .data_i  (w_data_q),
    .pop_i   (ps2pl_pop_s),
    .data_o  (ps2pl_data_o),
    .empty_o (ps2pl_empty_s),
    .full_o  (ps2pl_full_s),
    .count_o (ps2pl_count_s)
  );

  zynq_axil_fifo_bridge_fifo #(.width_p(32), .els_p(fifo_els_p)) pl2ps_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (pl2ps_push_s),
    .data_i  (pl2ps_data_i),
    .pop_i   (pl2ps_pop_s),
    .data_o  (pl2ps_head_s),
    .empty_o (pl2ps_empty_s),
    .full_o  (pl2ps_full_s),
    .count_o (pl2ps_count_s)
  );
endmodule

// File: tb/tb_zynq_axil_fifo_bridge.sv
// Directed bench for zynq_axil_fifo_bridge: CSR map, both FIFOs, error bits,
// AW/W skew, B back-pressure and mid-transaction reset.
module tb_zynq_axil_fifo_bridge;
  logic        aclk;
  logic        aresetn;
  logic [31:0] ps2pl_data_o;
  logic        ps2pl_v_o;
  logic        ps2pl_ready_i;
  logic [31:0] pl2ps_data_i;
  logic        pl2ps_v_i;
  logic        pl2ps_ready_o;

  int          n_vec;
  int          n_err;
  int          b_cnt;
  logic        bvalid_prev;
  logic [31:0] ps_q[$];

  zynq_axil_fifo_bridge_if #(.addr_width_p(10)) bus ();

  zynq_axil_fifo_bridge #(.addr_width_p(10), .data_width_p(32), .fifo_els_p(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s00           (bus.slave),
    .ps2pl_data_o  (ps2pl_data_o),
    .ps2pl_v_o     (ps2pl_v_o),
    .ps2pl_ready_i (ps2pl_ready_i),
    .pl2ps_data_i  (pl2ps_data_i),
    .pl2ps_v_i     (pl2ps_v_i),
    .pl2ps_ready_o (pl2ps_ready_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count B responses by rising bvalid, and collect words delivered to PL.
  always @(negedge aclk) begin
    if (bus.bvalid && !bvalid_prev) b_cnt <= b_cnt + 1;
    bvalid_prev <= bus.bvalid;
    if (aresetn && ps2pl_v_o && ps2pl_ready_i) ps_q.push_back(ps2pl_data_o);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    int   cyc;
    logic aw_done, w_done, aw_go, w_go;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0; resp = 2'b11;
    @(negedge aclk);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done) && cyc < 100) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      aw_go = bus.awvalid & bus.awready;
      w_go  = bus.wvalid & bus.wready;
      @(negedge aclk);
      aw_done = aw_done | aw_go;
      w_done  = w_done | w_go;
      cyc++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      check_eq("aw_w_timeout", {30'd0, aw_done, w_done}, 32'd3);
    end else begin
      cyc = 0;
      while (!bus.bvalid && cyc < 100) begin
        @(negedge aclk);
        cyc++;
      end
      if (!bus.bvalid) begin
        check_eq("b_timeout", 32'd0, 32'd1);
      end else begin
        for (int i = 0; i < b_dly; i++) begin
          check_eq("b_hold_bvalid_awready", {30'd0, bus.bvalid, bus.awready}, 32'd2);
          @(negedge aclk);
        end
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
      end
    end
  endtask

  task automatic axi_read(input logic [9:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int   cyc;
    logic go;
    data = 32'hFFFF_FFFF; resp = 2'b11; go = 1'b0; cyc = 0;
    @(negedge aclk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!go && cyc < 100) begin
      go = bus.arready;
      @(negedge aclk);
      cyc++;
    end
    bus.arvalid = 1'b0;
    if (!go) begin
      check_eq("ar_timeout", 32'd0, 32'd1);
    end else begin
      cyc = 0;
      while (!bus.rvalid && cyc < 100) begin
        @(negedge aclk);
        cyc++;
      end
      if (!bus.rvalid) begin
        check_eq("r_timeout", 32'd0, 32'd1);
      end else begin
        data = bus.rdata; resp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
      end
    end
  endtask

  task automatic pl_push(input logic [31:0] d);
    int   cyc;
    logic go;
    go = 1'b0; cyc = 0;
    @(negedge aclk);
    pl2ps_data_i = d; pl2ps_v_i = 1'b1;
    while (!go && cyc < 100) begin
      go = pl2ps_ready_o;
      @(negedge aclk);
      cyc++;
    end
    pl2ps_v_i = 1'b0;
    if (!go) check_eq("pl_push_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_ps_ready(input logic v);
    @(posedge aclk);
    #1 ps2pl_ready_i = v;
    @(negedge aclk);
  endtask

  task automatic read_check(input string tag, input logic [9:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check_eq(tag, d, exp_d);
    check_eq({tag, "_resp"}, {30'd0, r}, {30'd0, exp_r});
  endtask

  initial begin
    logic [1:0] rsp;
    logic       rst_bad;
    int         ok_cnt;
    int         b_before;
    int         cyc;
    logic       go;

    n_vec = 0; n_err = 0; b_cnt = 0; bvalid_prev = 1'b0;
    aresetn = 1'b0;
    bus.awaddr = '0; bus.awprot = 3'd0; bus.awvalid = 1'b0;
    bus.wdata = 32'd0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = 3'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    ps2pl_ready_i = 1'b0; pl2ps_data_i = 32'd0; pl2ps_v_i = 1'b0;

    rst_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      rst_bad = rst_bad | bus.awready | bus.wready | bus.arready | bus.bvalid | bus.rvalid
              | ps2pl_v_o | pl2ps_ready_o | (|bus.rdata) | (|bus.bresp) | (|bus.rresp);
    end
    check_eq("reset_outputs_zero", {31'd0, rst_bad}, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_eq("readies_after_reset", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);

    read_check("free_after_reset", 10'h004, 32'd16, 2'b00);
    read_check("occ_after_reset", 10'h008, 32'd0, 2'b00);

    // Single push delivered straight to PL
    set_ps_ready(1'b1);
    axi_write(10'h00C, 32'hDEADBEEF, 4'hF, 0, 0, 0, rsp);
    check_eq("push_resp", {30'd0, rsp}, 32'd0);
    repeat (3) @(negedge aclk);
    check_eq("ps2pl_count", ps_q.size(), 32'd1);
    if (ps_q.size() > 0) check_eq("ps2pl_word", ps_q[0], 32'hDEADBEEF);
    ps_q.delete();

    // Scratch with partial strobes
    axi_write(10'h000, 32'h12345678, 4'hF, 0, 0, 0, rsp);
    axi_write(10'h001, 32'hAABBCCDD, 4'b0101, 0, 0, 0, rsp);
    check_eq("scratch_wr_resp", {30'd0, rsp}, 32'd0);
    read_check("scratch_strobe", 10'h000, 32'h12BB56DD, 2'b00);

    // Fill PS2PL with the consumer stalled, overflow once
    set_ps_ready(1'b0);
    ok_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      axi_write(10'h00C, 32'h100 + i, 4'hF, 0, 0, 0, rsp);
      if (rsp == 2'b00) ok_cnt++;
    end
    check_eq("fill_ok_count", ok_cnt, 32'd16);
    axi_write(10'h00C, 32'hBAD0BAD0, 4'hF, 0, 0, 0, rsp);
    check_eq("overflow_resp", {30'd0, rsp}, 32'd2);
    read_check("err_overflow", 10'h014, 32'h1, 2'b00);
    read_check("free_when_full", 10'h004, 32'd0, 2'b00);
    axi_write(10'h014, 32'h1, 4'hF, 0, 0, 0, rsp);
    read_check("err_cleared", 10'h014, 32'h0, 2'b00);
    set_ps_ready(1'b1);
    repeat (20) @(negedge aclk);
    check_eq("drain_count", ps_q.size(), 32'd16);
    if (ps_q.size() == 16) begin
      check_eq("drain_first", ps_q[0], 32'h100);
      check_eq("drain_last", ps_q[15], 32'h10F);
    end
    ps_q.delete();

    // Push with a partial strobe is rejected
    axi_write(10'h00C, 32'h5555AAAA, 4'h3, 0, 0, 0, rsp);
    check_eq("badstrb_resp", {30'd0, rsp}, 32'd2);
    repeat (3) @(negedge aclk);
    check_eq("badstrb_no_push", ps_q.size(), 32'd0);
    read_check("err_badstrb", 10'h014, 32'h4, 2'b00);
    axi_write(10'h014, 32'hF, 4'hF, 0, 0, 0, rsp);

    // PL2PS pops and underflow
    pl_push(32'h1); pl_push(32'h2); pl_push(32'h3);
    read_check("occ_three", 10'h008, 32'd3, 2'b00);
    read_check("pop1", 10'h010, 32'h1, 2'b00);
    read_check("pop2", 10'h010, 32'h2, 2'b00);
    read_check("pop3", 10'h010, 32'h3, 2'b00);
    read_check("pop_empty", 10'h010, 32'h0, 2'b10);
    read_check("err_underflow", 10'h014, 32'h2, 2'b00);
    axi_write(10'h014, 32'hF, 4'hF, 0, 0, 0, rsp);

    // Unmapped, RO and WO accesses
    read_check("rd_unmapped", 10'h018, 32'h0, 2'b10);
    read_check("rd_push_reg", 10'h00C, 32'h0, 2'b10);
    axi_write(10'h004, 32'h1234, 4'hF, 0, 0, 0, rsp);
    check_eq("wr_ro_resp", {30'd0, rsp}, 32'd2);
    axi_write(10'h040, 32'h9999, 4'hF, 0, 0, 0, rsp);
    check_eq("wr_alias_unmapped_resp", {30'd0, rsp}, 32'd2);
    read_check("err_access", 10'h014, 32'h8, 2'b00);
    read_check("scratch_untouched", 10'h000, 32'h12BB56DD, 2'b00);
    axi_write(10'h014, 32'hF, 4'hF, 0, 0, 0, rsp);

    // AW/W skew with B back-pressure
    b_before = b_cnt;
    axi_write(10'h000, 32'h55, 4'hF, 3, 0, 5, rsp);
    check_eq("aw_late_resp", {30'd0, rsp}, 32'd0);
    check_eq("aw_late_bcount", b_cnt - b_before, 32'd1);
    b_before = b_cnt;
    axi_write(10'h000, 32'h66, 4'hF, 0, 3, 5, rsp);
    check_eq("w_late_resp", {30'd0, rsp}, 32'd0);
    check_eq("w_late_bcount", b_cnt - b_before, 32'd1);
    read_check("scratch_skew", 10'h000, 32'h66, 2'b00);

    // Reset with traffic in flight
    set_ps_ready(1'b0);
    for (int i = 0; i < 5; i++) axi_write(10'h00C, 32'h200 + i, 4'hF, 0, 0, 0, rsp);
    for (int i = 0; i < 5; i++) pl_push(32'h300 + i);
    read_check("free_five", 10'h004, 32'd11, 2'b00);
    read_check("occ_five", 10'h008, 32'd5, 2'b00);
    @(negedge aclk);
    bus.araddr = 10'h000; bus.arvalid = 1'b1;
    go = 1'b0; cyc = 0;
    while (!go && cyc < 100) begin
      go = bus.arready;
      @(negedge aclk);
      cyc++;
    end
    bus.arvalid = 1'b0;
    check_eq("rvalid_pending", {31'd0, bus.rvalid}, 32'd1);
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_eq("outputs_in_reset", {29'd0, bus.rvalid, ps2pl_v_o, pl2ps_ready_o}, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_eq("rvalid_after_reset", {31'd0, bus.rvalid}, 32'd0);
    read_check("occ_flushed", 10'h008, 32'd0, 2'b00);
    read_check("free_flushed", 10'h004, 32'd16, 2'b00);
    read_check("scratch_reset", 10'h000, 32'h0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
